// File: rtl/oversampler_pkg.sv
// Shared types and constants for the oversampler phase-scan slice.
package oversampler_pkg;

  localparam int unsigned NUM_PHASES  = 8;
  localparam int unsigned PHASE_SEL_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_COUNT,
    ST_NEXT,
    ST_SELECT,
    ST_LOCKED
  } scan_state_t;

endpackage

// File: rtl/err_window_counter.sv
// Synchronizes the oversampler error flag and counts it, saturating,
// over one WINDOW-cycle window. Shared by scan and lock-monitor windows.
module err_window_counter
  import oversampler_pkg::*;
#(
  parameter int unsigned WINDOW = 1024,
  parameter int unsigned CNT_W  = $clog2(WINDOW + 1)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             phase_err,
  input  logic             clear,
  input  logic             start,
  output logic             done,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned      CYC_W = $clog2(WINDOW + 1);
  localparam logic [CYC_W-1:0] LAST  = CYC_W'(WINDOW - 1);

  logic [1:0]       sync_q;
  logic             err_bit;
  logic             running;
  logic [CYC_W-1:0] cyc_q;
  logic [CNT_W-1:0] err_q;

  // Two-flop synchronizer for the fast-domain error flag.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) sync_q <= '0;
    else          sync_q <= {sync_q[0], phase_err};
  end

  assign err_bit = sync_q[1];

  // Saturating count including the current cycle's sample, so done and
  // count are valid together in the last window cycle.
  always_comb begin
    count = err_q;
    if (err_bit && (err_q != '1)) count = err_q + CNT_W'(1);
  end

  assign done = running && (cyc_q == LAST);

  // Window sequencing: clear aborts, start (re)opens a fresh window.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      running <= 1'b0;
      cyc_q   <= '0;
      err_q   <= '0;
    end else if (clear) begin
      running <= 1'b0;
      cyc_q   <= '0;
      err_q   <= '0;
    end else if (start) begin
      running <= 1'b1;
      cyc_q   <= '0;
      err_q   <= '0;
    end else if (running) begin
      err_q <= count;
      if (done) running <= 1'b0;
      else      cyc_q   <= cyc_q + CYC_W'(1);
    end
  end

endmodule

// File: rtl/oversampler_phase_scan.sv
// Phase-scan controller: scans all 8 phase_sel settings, locks onto the
// one with the fewest errors, then monitors the error rate.
// Optional feature macro: OVERSAMPLER_AUTO_RESCAN_EN (bad window in
// LOCKED triggers an automatic rescan).
module oversampler_phase_scan
  import oversampler_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned WINDOW        = 1024,
  parameter int unsigned CNT_W         = $clog2(WINDOW + 1),
  parameter int unsigned FAIL_THRESH   = 0,
  parameter int unsigned LOCK_THRESH   = 4
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   phase_err,
  input  logic                   start,
  output logic [PHASE_SEL_W-1:0] phase_sel,
  output logic                   busy,
  output logic                   locked,
  output logic                   scan_fail,
  output logic [CNT_W-1:0]       best_cnt,
  output logic [7:0]             relock_cnt
);

  localparam int unsigned      SET_W       = $clog2(SETTLE_CYCLES + 1);
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] FAIL_LIM    = CNT_W'(FAIL_THRESH);
  localparam logic [CNT_W-1:0] LOCK_LIM    = CNT_W'(LOCK_THRESH);

  scan_state_t            state_q, state_d;
  logic [PHASE_SEL_W-1:0] idx_q;
  logic [SET_W-1:0]       settle_q;
  logic [CNT_W-1:0]       phase_cnt_q [NUM_PHASES];

  logic                   win_clear, win_start, win_done;
  logic [CNT_W-1:0]       win_count;
  logic                   scan_begin, scan_pass, lock_bad, rescan_req;
  logic                   last_phase, settle_done;
  logic [PHASE_SEL_W-1:0] min_idx;
  logic [CNT_W-1:0]       min_val;

  err_window_counter #(
    .WINDOW (WINDOW),
    .CNT_W  (CNT_W)
  ) u_win (
    .clock     (clock),
    .reset_n   (reset_n),
    .phase_err (phase_err),
    .clear     (win_clear),
    .start     (win_start),
    .done      (win_done),
    .count     (win_count)
  );

  assign last_phase  = (idx_q == PHASE_SEL_W'(NUM_PHASES - 1));
  assign settle_done = (settle_q == SETTLE_LAST);
  assign scan_pass   = (min_val <= FAIL_LIM);
  assign lock_bad    = (state_q == ST_LOCKED) && win_done && (win_count > LOCK_LIM);
  assign busy        = (state_q == ST_SETTLE) || (state_q == ST_COUNT) ||
                       (state_q == ST_NEXT)   || (state_q == ST_SELECT);
  assign locked      = (state_q == ST_LOCKED);

`ifdef OVERSAMPLER_AUTO_RESCAN_EN
  assign rescan_req = start || lock_bad;
`else
  assign rescan_req = start;
`endif

  // Minimum search over the per-phase counts; strict < keeps the lowest index on ties.
  always_comb begin
    min_idx = '0;
    min_val = phase_cnt_q[0];
    for (int unsigned i = 1; i < NUM_PHASES; i++) begin
      if (phase_cnt_q[i] < min_val) begin
        min_val = phase_cnt_q[i];
        min_idx = PHASE_SEL_W'(i);
      end
    end
  end

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state and window-control strobes.
  always_comb begin
    state_d    = state_q;
    win_clear  = 1'b0;
    win_start  = 1'b0;
    scan_begin = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_SETTLE;
          scan_begin = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (settle_done) begin
          state_d   = ST_COUNT;
          win_start = 1'b1;
        end
      end
      ST_COUNT: begin
        if (win_done) state_d = ST_NEXT;
      end
      ST_NEXT: begin
        state_d = last_phase ? ST_SELECT : ST_SETTLE;
      end
      ST_SELECT: begin
        if (scan_pass) begin
          state_d   = ST_LOCKED;
          win_start = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOCKED: begin
        if (rescan_req) begin
          state_d    = ST_SETTLE;
          scan_begin = 1'b1;
          win_clear  = 1'b1;
        end else if (win_done) begin
          win_start = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Scan datapath: settle timer, phase index/select, results and lock monitor.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      idx_q      <= '0;
      settle_q   <= '0;
      phase_sel  <= '0;
      scan_fail  <= 1'b0;
      best_cnt   <= '0;
      relock_cnt <= '0;
      for (int unsigned i = 0; i < NUM_PHASES; i++) phase_cnt_q[i] <= '0;
    end else begin
      if (state_q == ST_SETTLE) settle_q <= settle_q + SET_W'(1);
      else                      settle_q <= '0;

      if (scan_begin) begin
        idx_q     <= '0;
        phase_sel <= '0;
        scan_fail <= 1'b0;
      end else if ((state_q == ST_NEXT) && !last_phase) begin
        idx_q     <= idx_q + PHASE_SEL_W'(1);
        phase_sel <= idx_q + PHASE_SEL_W'(1);
      end else if (state_q == ST_SELECT) begin
        best_cnt <= min_val;
        if (scan_pass) begin
          phase_sel <= min_idx;
        end else begin
          phase_sel <= '0;
          scan_fail <= 1'b1;
        end
      end

      if ((state_q == ST_COUNT) && win_done) phase_cnt_q[idx_q] <= win_count;

      // Counted even when a simultaneous start wins the state transition.
      if (lock_bad && (relock_cnt != '1)) relock_cnt <= relock_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_oversampler_phase_scan.sv
// Self-checking bench for oversampler_phase_scan with a behavioural
// oversampler model (per-phase error mode: clean, stuck, alternating).
module tb_oversampler_phase_scan;

  localparam int unsigned SC       = 6;
  localparam int unsigned WN       = 40;
  localparam int unsigned CW       = $clog2(WN + 1);
  localparam int          SCAN_LEN = 1 + 8 * (SC + WN + 1) + 1;

  logic          clock;
  logic          reset_n;
  logic          phase_err;
  logic          start;
  logic [2:0]    phase_sel;
  logic          busy;
  logic          locked;
  logic          scan_fail;
  logic [CW-1:0] best_cnt;
  logic [7:0]    relock_cnt;

  logic [1:0]    mode [8];
  logic          inject;
  logic          tog;

  int n_pass;
  int n_total;

  oversampler_phase_scan #(
    .SETTLE_CYCLES (SC),
    .WINDOW        (WN),
    .FAIL_THRESH   (0),
    .LOCK_THRESH   (4)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .phase_err  (phase_err),
    .start      (start),
    .phase_sel  (phase_sel),
    .busy       (busy),
    .locked     (locked),
    .scan_fail  (scan_fail),
    .best_cnt   (best_cnt),
    .relock_cnt (relock_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Alternating error source, toggled away from the sampling edge.
  initial tog = 1'b0;
  always @(negedge clock) tog <= ~tog;

  // Oversampler model: error behaviour depends on the selected phase.
  always_comb begin
    phase_err = inject;
    case (mode[phase_sel])
      2'd1:    phase_err = 1'b1;
      2'd2:    phase_err = inject | tog;
      default: phase_err = inject;
    endcase
  end

  // Expected scan outcome from per-phase error counts: clean = 0,
  // stuck = WN, alternating = WN/2; lowest index wins ties.
  function automatic void model_scan(output bit lock_e, output logic [2:0] sel_e,
                                     output logic [CW-1:0] best_e);
    int cnt [8];
    int best_i;
    for (int i = 0; i < 8; i++)
      cnt[i] = (mode[i] == 2'd0) ? 0 : (mode[i] == 2'd1) ? WN : WN / 2;
    best_i = 0;
    for (int i = 1; i < 8; i++)
      if (cnt[i] < cnt[best_i]) best_i = i;
    lock_e = (cnt[best_i] == 0);
    sel_e  = lock_e ? 3'(best_i) : 3'd0;
    best_e = CW'(cnt[best_i]);
  endfunction

  task automatic set_tie_modes();
    for (int i = 0; i < 8; i++) mode[i] = (i == 3 || i == 4) ? 2'd0 : 2'd1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    start   = 1'b0;
    inject  = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
    @(posedge clock);
    #1;
  endtask

  // Pulses start and counts cycles (start edge = 1) until locked or scan_fail.
  task automatic run_scan(input bit spam, output int n);
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    n = 1;
    while (n < SCAN_LEN + 50) begin
      if (locked || scan_fail) break;
      if (spam) start = ($urandom_range(0, 2) == 0);
      @(posedge clock);
      #1;
      n++;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    start   = 1'b0;
    inject  = 1'b0;
    for (int i = 0; i < 8; i++) mode[i] = 2'd0;
    repeat (2) @(posedge clock);
    #1;
    n_total++;
    if ({phase_sel, busy, locked, scan_fail, best_cnt, relock_cnt} !== '0) begin
      $display("FAIL reset_vals got sel=%0d busy=%0b lock=%0b fail=%0b best=%0d relock=%0d want all 0",
               phase_sel, busy, locked, scan_fail, best_cnt, relock_cnt);
    end else n_pass++;
    reset_n = 1'b1;
    repeat (10) @(posedge clock);
    #1;
    n_total++;
    if (busy !== 1'b0 || locked !== 1'b0) begin
      $display("FAIL idle_no_start got busy=%0b lock=%0b want 0 0", busy, locked);
    end else n_pass++;
  endtask

  task automatic test_tie_scan();
    int n;
    do_reset();
    set_tie_modes();
    run_scan(1'b0, n);
    n_total++;
    if (n !== SCAN_LEN) $display("FAIL tie_len got %0d want %0d", n, SCAN_LEN);
    else n_pass++;
    n_total++;
    if (locked !== 1'b1 || phase_sel !== 3'd3 || best_cnt !== '0 || busy !== 1'b0 || scan_fail !== 1'b0)
      $display("FAIL tie_result got lock=%0b sel=%0d best=%0d busy=%0b fail=%0b want 1 3 0 0 0",
               locked, phase_sel, best_cnt, busy, scan_fail);
    else n_pass++;
  endtask

  task automatic test_fail_all();
    int n;
    do_reset();
    for (int i = 0; i < 8; i++) mode[i] = 2'd1;
    run_scan(1'b0, n);
    n_total++;
    if (n !== SCAN_LEN) $display("FAIL fail_len got %0d want %0d", n, SCAN_LEN);
    else n_pass++;
    n_total++;
    if (scan_fail !== 1'b1 || locked !== 1'b0 || phase_sel !== 3'd0 || best_cnt !== CW'(WN) || busy !== 1'b0)
      $display("FAIL fail_result got fail=%0b lock=%0b sel=%0d best=%0d busy=%0b want 1 0 0 %0d 0",
               scan_fail, locked, phase_sel, best_cnt, busy, WN);
    else n_pass++;
    repeat (5) @(posedge clock);
    #1 start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    n_total++;
    if (scan_fail !== 1'b0 || busy !== 1'b1)
      $display("FAIL fail_clear got fail=%0b busy=%0b want 0 1", scan_fail, busy);
    else n_pass++;
  endtask

  task automatic test_random_scans();
    int n;
    bit lock_e;
    logic [2:0] sel_e;
    logic [CW-1:0] best_e;
    do_reset();
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < 8; i++) mode[i] = 2'($urandom_range(0, 2));
      if (it == 0) for (int i = 0; i < 8; i++) mode[i] = (i == 7) ? 2'd0 : 2'd2;
      if (it == 1) for (int i = 0; i < 8; i++) mode[i] = 2'd2;
      model_scan(lock_e, sel_e, best_e);
      run_scan(1'b0, n);
      n_total++;
      if (n !== SCAN_LEN) $display("FAIL rand_len[%0d] got %0d want %0d", it, n, SCAN_LEN);
      else n_pass++;
      n_total++;
      if (locked !== lock_e || scan_fail !== !lock_e || phase_sel !== sel_e || best_cnt !== best_e)
        $display("FAIL rand_result[%0d] got lock=%0b fail=%0b sel=%0d best=%0d want %0b %0b %0d %0d",
                 it, locked, scan_fail, phase_sel, best_cnt, lock_e, !lock_e, sel_e, best_e);
      else n_pass++;
      repeat (2) @(posedge clock);
      #1;
    end
  endtask

  task automatic test_start_spam();
    int n;
    do_reset();
    set_tie_modes();
    run_scan(1'b1, n);
    n_total++;
    if (n !== SCAN_LEN || locked !== 1'b1 || phase_sel !== 3'd3)
      $display("FAIL spam_scan got len=%0d lock=%0b sel=%0d want %0d 1 3", n, locked, phase_sel, SCAN_LEN);
    else n_pass++;
    repeat (3) @(posedge clock);
    #1 start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    n_total++;
    if (locked !== 1'b0 || busy !== 1'b1 || phase_sel !== 3'd0)
      $display("FAIL locked_restart got lock=%0b busy=%0b sel=%0d want 0 1 0", locked, busy, phase_sel);
    else n_pass++;
  endtask

  task automatic test_bad_window();
    int n;
    do_reset();
    set_tie_modes();
    run_scan(1'b0, n);
    // Now just after the edge that entered LOCKED; first window ends WN edges later.
    repeat (10) @(posedge clock);
    #1 inject = 1'b1;
    repeat (5) @(posedge clock);
    #1 inject = 1'b0;
    repeat (WN - 16) @(posedge clock);
    #1;
    n_total++;
    if (relock_cnt !== 8'd0 || locked !== 1'b1)
      $display("FAIL bad_pre got relock=%0d lock=%0b want 0 1", relock_cnt, locked);
    else n_pass++;
    @(posedge clock);
    #1;
    n_total++;
    if (relock_cnt !== 8'd1) $display("FAIL bad_relock got %0d want 1", relock_cnt);
    else n_pass++;
`ifdef OVERSAMPLER_AUTO_RESCAN_EN
    n_total++;
    if (busy !== 1'b1 || phase_sel !== 3'd0 || locked !== 1'b0)
      $display("FAIL auto_rescan got busy=%0b sel=%0d lock=%0b want 1 0 0", busy, phase_sel, locked);
    else n_pass++;
`else
    n_total++;
    if (locked !== 1'b1 || phase_sel !== 3'd3 || busy !== 1'b0)
      $display("FAIL stay_locked got lock=%0b sel=%0d busy=%0b want 1 3 0", locked, phase_sel, busy);
    else n_pass++;
    repeat (WN) @(posedge clock);
    #1;
    n_total++;
    if (relock_cnt !== 8'd1) $display("FAIL clean_window got relock=%0d want 1", relock_cnt);
    else n_pass++;
`endif
  endtask

  task automatic test_start_vs_bad();
    int n;
    do_reset();
    set_tie_modes();
    run_scan(1'b0, n);
    inject = 1'b1;
    repeat (WN - 1) @(posedge clock);
    #1 start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    inject = 1'b0;
    n_total++;
    if (relock_cnt !== 8'd1 || busy !== 1'b1 || locked !== 1'b0 || phase_sel !== 3'd0)
      $display("FAIL start_vs_bad got relock=%0d busy=%0b lock=%0b sel=%0d want 1 1 0 0",
               relock_cnt, busy, locked, phase_sel);
    else n_pass++;
  endtask

  task automatic test_reset_midscan();
    int n;
    do_reset();
    set_tie_modes();
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    repeat (199) @(posedge clock);
    #1;
    // 200 cycles in: phase index 4 (each phase takes SC+WN+1 = 47 cycles).
    n_total++;
    if (busy !== 1'b1 || phase_sel !== 3'd4)
      $display("FAIL midscan got busy=%0b sel=%0d want 1 4", busy, phase_sel);
    else n_pass++;
    reset_n = 1'b0;
    #1;
    n_total++;
    if ({phase_sel, busy, locked, scan_fail, best_cnt, relock_cnt} !== '0)
      $display("FAIL async_reset got sel=%0d busy=%0b lock=%0b fail=%0b best=%0d relock=%0d want all 0",
               phase_sel, busy, locked, scan_fail, best_cnt, relock_cnt);
    else n_pass++;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    repeat (20) @(posedge clock);
    #1;
    n = 0;
    n_total++;
    if (busy !== 1'b0 || locked !== 1'b0 || phase_sel !== 3'd0)
      $display("FAIL post_reset_idle got busy=%0b lock=%0b sel=%0d want 0 0 0", busy, locked, phase_sel);
    else n_pass++;
  endtask

  task automatic test_relock_saturate();
    int n;
    do_reset();
    set_tie_modes();
    run_scan(1'b0, n);
    inject = 1'b1;
    repeat (10 * WN) @(posedge clock);
    #1;
    n_total++;
    if (relock_cnt !== 8'd10) $display("FAIL relock_10 got %0d want 10", relock_cnt);
    else n_pass++;
    repeat (290 * WN) @(posedge clock);
    #1 inject = 1'b0;
    n_total++;
    if (relock_cnt !== 8'd255 || locked !== 1'b1)
      $display("FAIL relock_sat got relock=%0d lock=%0b want 255 1", relock_cnt, locked);
    else n_pass++;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    test_reset();
    test_tie_scan();
    test_fail_all();
    test_random_scans();
    test_start_spam();
    test_bad_window();
    test_start_vs_bad();
    test_reset_midscan();
`ifndef OVERSAMPLER_AUTO_RESCAN_EN
    test_relock_saturate();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
